// File: rtl/lut_multiplier_seq_pkg.sv
// Shared definitions for the nibble-serial LUT multiplier.
// Provides the nibble width, the FSM state encoding and the 4x4 product
// function that backs the combinational LUT multiplier.
package lut_multiplier_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 4x4 unsigned product; maps onto a 256-entry table after synthesis
  function automatic logic [2*NIB_W-1:0] lut4(input logic [NIB_W-1:0] x,
                                              input logic [NIB_W-1:0] y);
    logic [2*NIB_W-1:0] p;
    p = '0;
    for (int k = 0; k < int'(NIB_W); k++) begin
      if (y[k]) p = p + ((2*NIB_W)'(x) << k);
    end
    return p;
  endfunction

endpackage

// File: rtl/lut_multiplier_4b.sv
// Combinational 4x4 unsigned LUT multiplier.
// Ports: reset (forces the product to zero), a/b nibble operands,
//        p_c combinational 8-bit product.
module lut_multiplier_4b
  import lut_multiplier_seq_pkg::*;
(
  input  logic                 reset,
  input  logic [NIB_W-1:0]     a,
  input  logic [NIB_W-1:0]     b,
  output logic [2*NIB_W-1:0]   p_c
);

  // Product lookup, squashed while the surrounding block is in reset
  always_comb begin
    p_c = '0;
    if (!reset) p_c = lut4(a, b);
  end

endmodule

// File: rtl/lut_multiplier_seq.sv
// Nibble-serial unsigned multiplier: one 4x4 partial product per clock,
// shifted and accumulated, with valid/ready on both sides.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with operands
//        a, b; out_valid/out_ready with product mul; busy while computing.
module lut_multiplier_seq
  import lut_multiplier_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   mul,
  output logic                 busy
);

  localparam int unsigned NIB = WIDTH / NIB_W;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  // Operand width must be a whole number of nibbles
  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
    $error("lut_multiplier_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t               state;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        i_q;
  logic [CW-1:0]        j_q;

  logic [NIB_W-1:0]     a_nib;
  logic [NIB_W-1:0]     b_nib;
  logic [2*NIB_W-1:0]   pp;
  logic [2*WIDTH-1:0]   pp_shift;
  logic [2*WIDTH-1:0]   acc_sum;

  // Nibble selects and barrel shift of the partial product to weight 16^(i+j)
  always_comb begin
    a_nib    = NIB_W'(a_q >> (NIB_W * 32'(i_q)));
    b_nib    = NIB_W'(b_q >> (NIB_W * 32'(j_q)));
    pp_shift = (2*WIDTH)'(pp) << (NIB_W * (32'(i_q) + 32'(j_q)));
    acc_sum  = acc + pp_shift;
  end

  lut_multiplier_4b u_lut (
    .reset (reset),
    .a     (a_nib),
    .b     (b_nib),
    .p_c   (pp)
  );

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mul       <= '0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= acc_sum;
          if (j_q == LAST) begin
            j_q <= '0;
            if (i_q == LAST) begin
              i_q       <= '0;
              mul       <= acc_sum;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_DONE;
            end else begin
              i_q <= i_q + CW'(1);
            end
          end else begin
            j_q <= j_q + CW'(1);
          end
        end
        ST_DONE: begin
          // No accept here; the next operands are taken from IDLE
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_multiplier_seq.sv
// Directed bench for lut_multiplier_seq at WIDTH=8, 16 and 4.
module tb_lut_multiplier_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        rst8, iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] mul8;

  logic        rst16, iv16, ir16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] mul16;

  logic        rst4, iv4, ir4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  mul4;

  lut_multiplier_seq #(.WIDTH(8)) u_d8 (
    .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .mul(mul8), .busy(busy8));

  lut_multiplier_seq #(.WIDTH(16)) u_d16 (
    .clk(clk), .reset(rst16), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .mul(mul16), .busy(busy16));

  lut_multiplier_seq #(.WIDTH(4)) u_d4 (
    .clk(clk), .reset(rst4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .mul(mul4), .busy(busy4));

  // Offer operands, then count cycles until out_valid (bounded)
  task automatic push8(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int busy_n, output bit ir_low);
    int w;
    @(negedge clk);
    a8 = a; b8 = b; iv8 = 1'b1; w = 0;
    while (!ir8 && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    iv8 = 1'b0; ir_low = !ir8; lat = 0; busy_n = 0;
    while (!ov8 && lat < 100) begin
      if (busy8) busy_n++;
      @(negedge clk); lat++;
    end
  endtask

  task automatic pop8();
    or8 = 1'b1; @(negedge clk); or8 = 1'b0;
  endtask

  task automatic push16(input logic [15:0] a, input logic [15:0] b, output int lat);
    int w;
    @(negedge clk);
    a16 = a; b16 = b; iv16 = 1'b1; w = 0;
    while (!ir16 && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    iv16 = 1'b0; lat = 0;
    while (!ov16 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic pop16();
    or16 = 1'b1; @(negedge clk); or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst16 = 1'b1; rst4 = 1'b1;
    iv8 = 0; or8 = 0; a8 = '0; b8 = '0;
    iv16 = 0; or16 = 0; a16 = '0; b16 = '0;
    iv4 = 0; or4 = 0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({ir8, ov8, busy8, mul8} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      fails++;
      $display("FAIL reset8: ir=%b ov=%b busy=%b mul=%h want 1 0 0 0000", ir8, ov8, busy8, mul8);
    end
    tests++;
    if ({ir16, ov16, busy16, mul16, ir4, ov4, busy4, mul4} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0}) begin
      fails++;
      $display("FAIL reset16_4: ir16=%b ov16=%b mul16=%h ir4=%b ov4=%b mul4=%h want 1 0 0 1 0 0",
               ir16, ov16, mul16, ir4, ov4, mul4);
    end
    rst8 = 1'b0; rst16 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bn; bit irl;
    push8(8'hFF, 8'hFF, lat, bn, irl);
    tests++;
    if (!irl) begin fails++; $display("FAIL basic_in_ready: in_ready high after accept, want low"); end
    tests++;
    if (lat != 4) begin fails++; $display("FAIL basic_latency: got %0d want 4", lat); end
    tests++;
    if (bn != 4) begin fails++; $display("FAIL basic_busy: got %0d cycles want 4", bn); end
    tests++;
    if (mul8 !== 16'hFE01) begin fails++; $display("FAIL basic_mul: got %h want fe01", mul8); end
    pop8();
    tests++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      fails++; $display("FAIL basic_release: ov=%b ir=%b want 0 1", ov8, ir8);
    end
  endtask

  task automatic test_backpressure();
    int lat, bn; bit irl; int bad;
    push8(8'h12, 8'h34, lat, bn, irl);
    tests++;
    if (lat != 4 || mul8 !== 16'h03A8) begin
      fails++; $display("FAIL bp_first: lat=%0d mul=%h want 4 03a8", lat, mul8);
    end
    a8 = 8'h99; b8 = 8'h77; iv8 = 1'b1; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov8 !== 1'b1 || mul8 !== 16'h03A8 || ir8 !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL bp_hold: %0d unstable cycles want 0 (mul=%h)", bad, mul8); end
    iv8 = 1'b0;
    pop8();
    tests++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0 || mul8 !== 16'h03A8) begin
      fails++; $display("FAIL bp_idle: ov=%b ir=%b busy=%b mul=%h want 0 1 0 03a8", ov8, ir8, busy8, mul8);
    end
  endtask

  task automatic test_back_to_back();
    int c, p;
    or8 = 1'b1; a8 = 8'h03; b8 = 8'h07; iv8 = 1'b1; c = 0;
    @(negedge clk);
    while (!ov8 && c < 100) begin @(negedge clk); c++; end
    tests++;
    if (ov8 !== 1'b1 || mul8 !== 16'h0015) begin
      fails++; $display("FAIL b2b_first: ov=%b mul=%h want 1 0015", ov8, mul8);
    end
    @(negedge clk); p = 1;
    while (!ov8 && p < 100) begin @(negedge clk); p++; end
    iv8 = 1'b0;
    tests++;
    if (p != 6 || mul8 !== 16'h0015) begin
      fails++; $display("FAIL b2b_period: period=%0d mul=%h want 6 0015", p, mul8);
    end
    @(negedge clk);
    or8 = 1'b0;
    tests++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      fails++; $display("FAIL b2b_drain: ov=%b ir=%b want 0 1", ov8, ir8);
    end
  endtask

  task automatic test_reset_mid();
    int seen, lat, bn; bit irl;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'hAA; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    tests++;
    if ({ir8, ov8, busy8, mul8} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      fails++; $display("FAIL midreset_state: ir=%b ov=%b busy=%b mul=%h want 1 0 0 0000", ir8, ov8, busy8, mul8);
    end
    rst8 = 1'b0; seen = 0;
    repeat (8) begin @(negedge clk); if (ov8) seen++; end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL midreset_nopulse: out_valid seen %0d cycles want 0", seen); end
    push8(8'h03, 8'h05, lat, bn, irl);
    tests++;
    if (lat != 4 || mul8 !== 16'h000F) begin
      fails++; $display("FAIL midreset_followup: lat=%0d mul=%h want 4 000f", lat, mul8);
    end
    pop8();
  endtask

  task automatic test_wide16();
    int lat;
    push16(16'hFFFF, 16'hFFFF, lat);
    tests++;
    if (lat != 16 || mul16 !== 32'hFFFE0001) begin
      fails++; $display("FAIL w16_max: lat=%0d mul=%h want 16 fffe0001", lat, mul16);
    end
    pop16();
    push16(16'h0000, 16'hABCD, lat);
    tests++;
    if (lat != 16 || mul16 !== 32'h0) begin
      fails++; $display("FAIL w16_zero: lat=%0d mul=%h want 16 00000000", lat, mul16);
    end
    pop16();
  endtask

  task automatic test_nib1();
    int w, lat, bn;
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hE; iv4 = 1'b1; w = 0;
    while (!ir4 && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    iv4 = 1'b0; lat = 0; bn = 0;
    while (!ov4 && lat < 100) begin
      if (busy4) bn++;
      @(negedge clk); lat++;
    end
    tests++;
    if (lat != 1 || bn != 1 || mul4 !== 8'hD2) begin
      fails++; $display("FAIL w4_corner: lat=%0d busy=%0d mul=%h want 1 1 d2", lat, bn, mul4);
    end
    or4 = 1'b1; @(negedge clk); or4 = 1'b0;
    tests++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
      fails++; $display("FAIL w4_release: ov=%b ir=%b want 0 1", ov4, ir4);
    end
  endtask

  task automatic test_random();
    int lat, bn, stall; bit irl;
    logic [7:0]  ra, rb;
    logic [15:0] ra16, rb16;
    logic [15:0] exp8;
    logic [31:0] exp16;
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      exp8 = 16'(ra) * 16'(rb);
      stall = $urandom_range(0, 3);
      push8(ra, rb, lat, bn, irl);
      repeat (stall) @(negedge clk);
      tests++;
      if (ov8 !== 1'b1 || lat != 4 || mul8 !== exp8) begin
        fails++; $display("FAIL rand8 %h*%h: ov=%b lat=%0d mul=%h want 1 4 %h", ra, rb, ov8, lat, mul8, exp8);
      end
      pop8();
    end
    for (int n = 0; n < 100; n++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom);
      exp16 = 32'(ra16) * 32'(rb16);
      stall = $urandom_range(0, 3);
      push16(ra16, rb16, lat);
      repeat (stall) @(negedge clk);
      tests++;
      if (ov16 !== 1'b1 || lat != 16 || mul16 !== exp16) begin
        fails++; $display("FAIL rand16 %h*%h: ov=%b lat=%0d mul=%h want 1 16 %h", ra16, rb16, ov16, lat, mul16, exp16);
      end
      pop16();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wide16();
    test_nib1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
